// File: rtl/gpr_file_sb.sv
// Clocked integer register file with hardwired x0, optional write-to-read bypass and a
// per-register write-pending scoreboard for decode-stage hazard detection.
module gpr_file_sb #(
  parameter int unsigned NR_REGS = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned NR_RD   = 2,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_RD*ADDR_W-1:0]   rd_addr,
  output logic [NR_RD*DATA_W-1:0]   rd_data,
  output logic [NR_RD-1:0]          rd_busy,
  input  logic                      wen,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic                      flush,
  output logic [NR_REGS-1:0]        busy_vec
);

  logic [DATA_W-1:0]  regs_q [NR_REGS];
  logic [DATA_W-1:0]  regs_d [NR_REGS];
  logic [NR_REGS-1:0] busy_q, busy_d;
  logic [NR_REGS-1:0] wr_hit, iss_hit;

  // One-hot decodes; bit 0 and out-of-range addresses never match, which
  // makes x0 immune to writes/issues without separate range checks.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int unsigned r = 1; r < NR_REGS; r++) begin
      wr_hit[r]  = wen && (waddr == ADDR_W'(r));
      iss_hit[r] = issue_valid && (issue_addr == ADDR_W'(r));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned r = 1; r < NR_REGS; r++) begin
      if (wr_hit[r]) regs_d[r] = wdata;
    end
    // A new producer's set overrides a same-cycle write-back clear.
    if (flush) busy_d = '0;
    else       busy_d = (busy_q & ~wr_hit) | iss_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NR_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NR_RD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      for (int unsigned r = 1; r < NR_REGS; r++) begin
        if (a == ADDR_W'(r)) begin
          if ((BYPASS != 0) && wr_hit[r]) begin
            rd_data[i*DATA_W +: DATA_W] = wdata;
            rd_busy[i]                  = 1'b0;
          end else begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[r];
            rd_busy[i]                  = busy_q[r];
          end
        end
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb: default build with and without bypass, plus a reduced
// 16-register, 3-port, 32-bit build; expectations go through a scoreboard queue.
module tb_gpr_file_sb;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Shared stimulus for the default-size instances.
  logic [9:0]   rd_addr;
  logic         wen, issue_valid, flush;
  logic [4:0]   waddr, issue_addr;
  logic [63:0]  wdata;
  logic [127:0] rd_data, nb_rd_data;
  logic [1:0]   rd_busy, nb_rd_busy;
  logic [31:0]  busy_vec, nb_busy_vec;

  // Reduced build.
  logic [14:0]  p_rd_addr;
  logic         p_wen, p_issue_valid, p_flush;
  logic [4:0]   p_waddr, p_issue_addr;
  logic [31:0]  p_wdata;
  logic [95:0]  p_rd_data;
  logic [2:0]   p_rd_busy;
  logic [15:0]  p_busy_vec;

  gpr_file_sb u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .flush(flush), .busy_vec(busy_vec)
  );

  gpr_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .flush(flush), .busy_vec(nb_busy_vec)
  );

  gpr_file_sb #(.NR_REGS(16), .ADDR_W(5), .DATA_W(32), .NR_RD(3)) u_p (
    .clk(clk), .rst(rst), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .wen(p_wen), .waddr(p_waddr), .wdata(p_wdata), .issue_valid(p_issue_valid),
    .issue_addr(p_issue_addr), .flush(p_flush), .busy_vec(p_busy_vec)
  );

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    wen = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    p_wen = 1'b0; p_issue_valid = 1'b0; p_flush = 1'b0;
  endtask

  initial begin
    idle();
    rd_addr = {5'd5, 5'd5}; waddr = '0; wdata = '0; issue_addr = '0;
    p_rd_addr = '0; p_waddr = '0; p_wdata = '0; p_issue_addr = '0;

    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #1;
    push("rst_rd_data", '0);   pop_chk(rd_data);
    push("rst_rd_busy", '0);   pop_chk(128'(rd_busy));
    push("rst_busy_vec", '0);  pop_chk(128'(busy_vec));
    push("rst_p_rd_data", '0); pop_chk(128'(p_rd_data));
    rst = 1'b0;
    #1 clk_en = 1'b1;

    // Write x5, read back on port 1.
    @(negedge clk);
    wen = 1'b1; waddr = 5'd5; wdata = 64'hDEAD_BEEF_0000_0001; rd_addr = {5'd5, 5'd0};
    push("x5_next_cycle", 128'(64'hDEAD_BEEF_0000_0001));
    push("x5_rd_busy", 128'(2'b00));
    @(negedge clk);
    idle();
    #1;
    pop_chk(128'(rd_data[127:64]));
    pop_chk(128'(rd_busy));

    // x0: write and issue both ignored.
    @(negedge clk);
    wen = 1'b1; waddr = 5'd0; wdata = '1; issue_valid = 1'b1; issue_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    push("x0_same_cycle", '0); pop_chk(rd_data);
    @(negedge clk);
    idle();
    #1;
    push("x0_next_data", '0); pop_chk(rd_data);
    push("x0_busy_vec", '0);  pop_chk(128'(busy_vec));

    // Bypass vs registered-only reads on x10.
    @(negedge clk);
    wen = 1'b1; waddr = 5'd10; wdata = 64'h1111; rd_addr = {5'd10, 5'd10};
    @(negedge clk);
    wdata = 64'h1234;
    #1;
    push("byp_data", {64'h1234, 64'h1234});  pop_chk(rd_data);
    push("byp_busy", 128'(2'b00));           pop_chk(128'(rd_busy));
    push("nobyp_old", {64'h1111, 64'h1111}); pop_chk(nb_rd_data);
    @(negedge clk);
    idle();
    #1;
    push("nobyp_next", {64'h1234, 64'h1234}); pop_chk(nb_rd_data);

    // Scoreboard lifecycle on x7.
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd7; rd_addr = {5'd7, 5'd7};
    #1;
    push("life_c1_busy", 128'(2'b00)); pop_chk(128'(rd_busy));
    @(negedge clk);
    idle();
    #1;
    push("life_c2_busy", 128'(2'b11));         pop_chk(128'(rd_busy));
    push("life_c2_vec", 128'(32'h0000_0080));  pop_chk(128'(busy_vec));
    @(negedge clk);
    #1;
    push("life_c3_busy", 128'(2'b11)); pop_chk(128'(rd_busy));
    @(negedge clk);
    wen = 1'b1; waddr = 5'd7; wdata = 64'h55;
    #1;
    push("life_c4_busy", 128'(2'b00));      pop_chk(128'(rd_busy));
    push("life_c4_data", {64'h55, 64'h55}); pop_chk(rd_data);
    push("life_c4_nb_busy", 128'(2'b11));   pop_chk(128'(nb_rd_busy));
    push("life_c4_nb_data", '0);            pop_chk(nb_rd_data);
    @(negedge clk);
    idle();
    #1;
    push("life_c5_vec", '0);                   pop_chk(128'(busy_vec));
    push("life_c5_nb_data", {64'h55, 64'h55}); pop_chk(nb_rd_data);
    push("life_c5_nb_vec", '0);                pop_chk(128'(nb_busy_vec));

    // Issue beats same-cycle write-back on x3; flush clears and drops issue.
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd3; rd_addr = {5'd3, 5'd3};
    @(negedge clk);
    wen = 1'b1; waddr = 5'd3; wdata = 64'h77;
    #1;
    push("coll_nb_busy", 128'(2'b11)); pop_chk(128'(nb_rd_busy));
    @(negedge clk);
    idle();
    #1;
    push("coll_vec", 128'(32'h0000_0008));  pop_chk(128'(busy_vec));
    push("coll_data", {64'h77, 64'h77});    pop_chk(rd_data);
    push("coll_busy", 128'(2'b11));         pop_chk(128'(rd_busy));
    @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd4;
    wen = 1'b1; waddr = 5'd3; wdata = 64'h88;
    @(negedge clk);
    idle();
    #1;
    push("flush_vec", '0);                 pop_chk(128'(busy_vec));
    push("flush_data", {64'h88, 64'h88});  pop_chk(rd_data);

    // Reduced build: out-of-range address 20, then three-port reads.
    @(negedge clk);
    p_wen = 1'b1; p_waddr = 5'd20; p_wdata = 32'hCAFE;
    p_issue_valid = 1'b1; p_issue_addr = 5'd20; p_rd_addr = {5'd0, 5'd0, 5'd20};
    #1;
    push("p_oor_byp", '0);  pop_chk(128'(p_rd_data));
    push("p_oor_busy", '0); pop_chk(128'(p_rd_busy));
    @(negedge clk);
    idle();
    p_wen = 1'b1; p_waddr = 5'd1; p_wdata = 32'hA;
    #1;
    push("p_oor_read", '0); pop_chk(128'(p_rd_data));
    push("p_oor_vec", '0);  pop_chk(128'(p_busy_vec));
    @(negedge clk);
    p_waddr = 5'd2; p_wdata = 32'hB;
    @(negedge clk);
    idle();
    p_rd_addr = {5'd1, 5'd2, 5'd1};
    #1;
    push("p_three_ports", 128'({32'hA, 32'hB, 32'hA})); pop_chk(128'(p_rd_data));

    // Async reset mid-run clears data and a pending busy bit.
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd12; rd_addr = {5'd7, 5'd5};
    @(negedge clk);
    idle();
    #1;
    push("pre_rst_vec", 128'(32'h0000_1000)); pop_chk(128'(busy_vec));
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    push("async_rst_vec", '0);  pop_chk(128'(busy_vec));
    push("async_rst_data", '0); pop_chk(rd_data);
    push("async_rst_p", '0);    pop_chk(128'(p_rd_data));
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised, clocked integer register file with a write-pending scoreboard.
- Supports N read ports, one write-back port and optional write-to-read bypass.
- Sits between decode (read/issue) and write-back in the NPC core.
- Adds over the previous combinational version:
  - true sequential write;
  - hardwired zero register;
  - reset clearing;
  - per-register busy tracking for hazard detection.

Parameters:
- NR_REGS, 32, number of architectural registers (2..2^ADDR_W).
- ADDR_W, 5, register address width.
- DATA_W, 64, register data width.
- NR_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see registered contents only.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset. Asynchronous, active-high.
- rd_addr  input  NR_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NR_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
- rd_busy  output  NR_RD  port i source register has a pending write.
- wen  input  1  write-back valid.
- waddr  input  ADDR_W  write-back register address.
- wdata  input  DATA_W  write-back data.
- issue_valid  input  1  instruction with a destination issued this cycle.
- issue_addr  input  ADDR_W  destination to mark busy.
- flush  input  1  clear all busy bits (pipeline flush).
- busy_vec  output  NR_REGS  raw scoreboard state, for debug/difftest.

Behaviour:
- Reset (rst=1, async, no clock needed): all registers = 0, all busy bits = 0. Hence rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reset takes effect immediately even mid-write. The first write is accepted on the first rising edge after rst deasserts.
- Register 0:
  - always reads 0;
  - writes to address 0 ignored;
  - issue to address 0 never sets busy;
  - busy_vec[0] is constant 0.
- Out-of-range address (>= NR_REGS):
  - reads return 0 with busy 0;
  - writes and issues ignored.
- Write: on rising clk with wen=1 and waddr valid and non-zero, reg[waddr] <= wdata. Visible through the array from the next cycle.
- Read: combinational, zero latency, per port independent.
- When BYPASS=1 and wen=1 and waddr==rd_addr[i] (non-zero, valid): rd_data[i] = wdata in the same cycle, otherwise reg[rd_addr[i]].
- When BYPASS=0, reads return the array contents only.
- Multiple read ports on the same address return identical data.
- Scoreboard, per register r, next-state on rising clk, priority high to low:
  1. flush=1: busy[r] <= 0 for all r. Pending issue is dropped. wen still writes data.
  2. issue_valid=1 and issue_addr==r: busy[r] <= 1. Set wins over a same-cycle write-back to the same r, because the new producer supersedes the old.
  3. wen=1 and waddr==r: busy[r] <= 0.
  4. Otherwise hold.
- rd_busy[i] is combinational:
  - rd_busy[i] = busy[rd_addr[i]];
  - except when BYPASS=1 and wen=1 and waddr==rd_addr[i], then rd_busy[i] = 0, since the data is being forwarded.
- Re-issue to an already-busy register keeps busy = 1; there is no counting, so only the latest producer is tracked.
- Write-back to a non-busy register is legal: data is written and busy stays 0.
- No internal handshake stall; the consumer uses rd_busy to stall decode.

Test Plan:
- Reset: rst pulse with clk stopped → all rd_data=0, busy_vec=0 immediately. Then write x5=64'hDEAD_BEEF_0000_0001 and read next cycle on port 1 → same value, rd_busy=0.
- Zero register: wen=1, waddr=0, wdata=64'hFFFF_FFFF_FFFF_FFFF, and issue_addr=0 → next cycle rd_data for address 0 is 0 and busy_vec[0]=0.
- Bypass: wen=1, waddr=10, wdata=64'h1234, rd_addr0=rd_addr1=10 in the same cycle.
  - BYPASS=1 → both ports 64'h1234, rd_busy=0.
  - BYPASS=0 → old value; 64'h1234 appears next cycle.
- Scoreboard lifecycle: issue x7 at cycle 1 → rd_busy=1 from cycle 2. Write x7=64'h55 at cycle 4 → cycle 4 rd_busy=0 and data 64'h55 (BYPASS=1); busy_vec[7]=0 from cycle 5.
- Collision: with x3 busy, drive issue_addr=3 and wen/waddr=3 in the same cycle → data written, busy_vec[3] stays 1. Then flush with issue_addr=4 → busy_vec all 0 next cycle.
- Parametrised build NR_REGS=16, ADDR_W=5, NR_RD=3, DATA_W=32: write address 20 → ignored, read of 20 returns 0. Three ports reading x1, x2, x1 after writes 32'hA, 32'hB → A, B, A.
